dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the shared 64-byte, byte-addressed, 64-bit-word data memory.
  - Port 0 is the pipeline MEM stage.
  - Port 1 is a loader/debug requester.
- Grants one access at a time using fixed priority with a starvation guard.
- Drives the memory's address, write data, read strobe and write strobe.
- Returns registered read data or an error per port, with fixed latency.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_prio_sel.sv | 16 +
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids
// and memory geometry.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int unsigned MEM_BYTES  = 64;
    localparam int unsigned WORD_BYTES = 8;
    localparam logic [2:0]  WORD_MASK  = 3'b111;

    // True when the low address bits select the first byte of a word.
    function automatic logic word_aligned(input logic [2:0] lsb);
        return (lsb & WORD_MASK) == 3'b000;
    endfunction

endpackage

// File: rtl/dmem_prio_sel.sv
// Winner selection between the pipeline port and the loader/debug port.
// Port 0 has fixed priority unless port 1 has been starved.
module dmem_prio_sel (
    input  logic p0_req,
    input  logic p1_req,
    input  logic starve,
    output logic grant0_c,
    output logic grant1_c
);

    always_comb begin
        grant1_c = p1_req & (starve | ~p0_req);
        grant0_c = p0_req & ~grant1_c;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the shared data memory.
// One access in flight: IDLE (grant) -> ACCESS (strobe) -> RESP (response).
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MEM_BYTES = dmem_pkg::MEM_BYTES,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    import dmem_pkg::*;

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_WAIT);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                cmd_port_q, cmd_port_d;
    logic                cmd_we_q, cmd_we_d;
    logic                cmd_err_q, cmd_err_d;

    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                mem_read_d, mem_write_d;
    logic                p0_rsp_valid_d, p1_rsp_valid_d;
    logic [DATA_W-1:0]   p0_rdata_d, p1_rdata_d;
    logic                p0_err_d, p1_err_d;

    logic                grant0_c, grant1_c;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                win_legal;
    logic [DATA_W-1:0]   rsp_data;

    dmem_prio_sel u_prio_sel (
        .p0_req   (p0_req),
        .p1_req   (p1_req),
        .starve   (wait_q == CNT_MAX),
        .grant0_c (grant0_c),
        .grant1_c (grant1_c)
    );

    // Grant is visible to the requester in the same IDLE cycle; quiet in reset.
    assign p0_ready = reset & (state_q == IDLE) & grant0_c;
    assign p1_ready = reset & (state_q == IDLE) & grant1_c;

    always_comb begin
        win_we    = grant1_c ? p1_we    : p0_we;
        win_addr  = grant1_c ? p1_addr  : p0_addr;
        win_wdata = grant1_c ? p1_wdata : p0_wdata;
        win_legal = word_aligned(win_addr[2:0]) && (win_addr <= LAST_WORD);
        rsp_data  = (cmd_err_q | cmd_we_q) ? '0 : mem_rdata;
    end

    // Next-state, command capture and response generation.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        cmd_port_d     = cmd_port_q;
        cmd_we_d       = cmd_we_q;
        cmd_err_d      = cmd_err_q;
        mem_addr_d     = '0;
        mem_wdata_d    = '0;
        mem_read_d     = 1'b0;
        mem_write_d    = 1'b0;
        p0_rsp_valid_d = 1'b0;
        p1_rsp_valid_d = 1'b0;
        p0_rdata_d     = p0_rdata;
        p1_rdata_d     = p1_rdata;
        p0_err_d       = p0_err;
        p1_err_d       = p1_err;

        case (state_q)
            IDLE: begin
                if (grant1_c) begin
                    wait_d = '0;
                end else if (p1_req && (wait_q != CNT_MAX)) begin
                    wait_d = wait_q + CNT_W'(1);
                end
                if (grant0_c || grant1_c) begin
                    cmd_port_d  = grant1_c ? PORT_DBG : PORT_CPU;
                    cmd_we_d    = win_we;
                    cmd_err_d   = ~win_legal;
                    mem_addr_d  = win_legal ? win_addr : '0;
                    mem_wdata_d = (win_legal && win_we) ? win_wdata : '0;
                    mem_read_d  = win_legal & ~win_we;
                    mem_write_d = win_legal & win_we;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cmd_port_q == PORT_DBG) begin
                    p1_rsp_valid_d = 1'b1;
                    p1_rdata_d     = rsp_data;
                    p1_err_d       = cmd_err_q;
                end else begin
                    p0_rsp_valid_d = 1'b1;
                    p0_rdata_d     = rsp_data;
                    p0_err_d       = cmd_err_q;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            cmd_port_q   <= PORT_CPU;
            cmd_we_q     <= 1'b0;
            cmd_err_q    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p0_rdata     <= '0;
            p1_rdata     <= '0;
            p0_err       <= 1'b0;
            p1_err       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            cmd_port_q   <= cmd_port_d;
            cmd_we_q     <= cmd_we_d;
            cmd_err_q    <= cmd_err_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            mem_read     <= mem_read_d;
            mem_write    <= mem_write_d;
            p0_rsp_valid <= p0_rsp_valid_d;
            p1_rsp_valid <= p1_rsp_valid_d;
            p0_rdata     <= p0_rdata_d;
            p1_rdata     <= p1_rdata_d;
            p0_err       <= p0_err_d;
            p1_err       <= p1_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [63:0] p0_addr = '0, p0_wdata = '0;
    logic        p0_ready, p0_rsp_valid, p0_err;
    logic [63:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [63:0] p1_addr = '0, p1_wdata = '0;
    logic        p1_ready, p1_rsp_valid, p1_err;
    logic [63:0] p1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [63:0] mem [0:7] = '{64'd120, 64'd100, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'h77};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:3]];
    always @(posedge clk) if (mem_write) mem[mem_addr[5:3]] <= mem_wdata;

    dmem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .p0_req       (p0_req),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_ready     (p0_ready),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rdata     (p0_rdata),
        .p0_err       (p0_err),
        .p1_req       (p1_req),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_ready     (p1_ready),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rdata     (p1_rdata),
        .p1_err       (p1_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access on a single port, checked at accept, strobe and response.
    task automatic xfer(input string tag, input logic port, input logic we,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err);
        logic legal;
        legal = ~exp_err;
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
        #1;
        check_eq({tag, "_rdy"}, {63'd0, port ? p1_ready : p0_ready}, 64'd1);
        check_eq({tag, "_other_rdy"}, {63'd0, port ? p0_ready : p1_ready}, 64'd0);
        tick();
        p0_req = 1'b0;
        p1_req = 1'b0;
        check_eq({tag, "_mrd"}, {63'd0, mem_read}, {63'd0, legal & ~we});
        check_eq({tag, "_mwr"}, {63'd0, mem_write}, {63'd0, legal & we});
        if (legal) check_eq({tag, "_maddr"}, mem_addr, addr);
        if (legal && we) check_eq({tag, "_mwdata"}, mem_wdata, wdata);
        tick();
        check_eq({tag, "_rspv"}, {63'd0, port ? p1_rsp_valid : p0_rsp_valid}, 64'd1);
        check_eq({tag, "_other_rspv"}, {63'd0, port ? p0_rsp_valid : p1_rsp_valid}, 64'd0);
        check_eq({tag, "_rdata"}, port ? p1_rdata : p0_rdata, exp_rdata);
        check_eq({tag, "_err"}, {63'd0, port ? p1_err : p0_err}, {63'd0, exp_err});
        check_eq({tag, "_mstb_resp"}, {62'd0, mem_read, mem_write}, 64'd0);
        tick();
        check_eq({tag, "_rspv_drop"}, {63'd0, port ? p1_rsp_valid : p0_rsp_valid}, 64'd0);
    endtask

    initial begin
        // Reset values, including ready gating while requests are present.
        p0_req = 1'b1;
        p1_req = 1'b1;
        #3;
        check_eq("rst_ready", {62'd0, p0_ready, p1_ready}, 64'd0);
        check_eq("rst_mem", {62'd0, mem_read, mem_write}, 64'd0);
        check_eq("rst_maddr", mem_addr, 64'd0);
        check_eq("rst_rsp", {60'd0, p0_rsp_valid, p1_rsp_valid, p0_err, p1_err}, 64'd0);
        check_eq("rst_rdata", p0_rdata | p1_rdata, 64'd0);
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick();
        reset = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle_flags", {58'd0, mem_read, mem_write, p0_ready, p1_ready,
                                    p0_rsp_valid, p1_rsp_valid}, 64'd0);
            check_eq("idle_maddr", mem_addr, 64'd0);
        end

        xfer("p0_rd8", 1'b0, 1'b0, 64'd8, 64'd0, 64'd100, 1'b0);
        xfer("p1_wr16", 1'b1, 1'b1, 64'd16, 64'h55, 64'd0, 1'b0);
        xfer("p1_rd16", 1'b1, 1'b0, 64'd16, 64'd0, 64'h55, 1'b0);

        // Both ports request continuously: four p0 grants, then forced p1, then p0.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 64'd0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 64'd8;
        for (int g = 0; g < 6; g++) begin
            #1;
            check_eq($sformatf("starve_p0rdy_%0d", g), {63'd0, p0_ready}, {63'd0, g != 4});
            check_eq($sformatf("starve_p1rdy_%0d", g), {63'd0, p1_ready}, {63'd0, g == 4});
            if (g < 5) begin
                tick();
                tick();
                check_eq($sformatf("starve_rdata_%0d", g), (g == 4) ? p1_rdata : p0_rdata,
                         (g == 4) ? 64'd100 : 64'd120);
                tick();
            end
        end
        tick();
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick();
        tick();

        // Illegal addresses and the last legal word.
        xfer("p0_mis12", 1'b0, 1'b0, 64'd12, 64'd0, 64'd0, 1'b1);
        xfer("p0_oor64", 1'b0, 1'b0, 64'd64, 64'd0, 64'd0, 1'b1);
        xfer("p0_wrap", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1);
        xfer("p0_wr_oor", 1'b0, 1'b1, 64'd60, 64'hDEAD, 64'd0, 1'b1);
        xfer("p0_rd56", 1'b0, 1'b0, 64'd56, 64'd0, 64'h77, 1'b0);

        // Reset in the middle of a write's ACCESS cycle.
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 64'd24; p0_wdata = 64'hAA;
        #1;
        check_eq("abort_rdy", {63'd0, p0_ready}, 64'd1);
        tick();
        p0_req = 1'b0;
        check_eq("abort_mwr_pre", {63'd0, mem_write}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_mwr_drop", {63'd0, mem_write}, 64'd0);
        check_eq("abort_maddr", mem_addr, 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("abort_no_rsp", {62'd0, p0_rsp_valid, p1_rsp_valid}, 64'd0);
        end
        reset = 1'b1;
        tick();
        check_eq("abort_no_rsp_after", {62'd0, p0_rsp_valid, p1_rsp_valid}, 64'd0);
        xfer("post_rst_rd24", 1'b0, 1'b0, 64'd24, 64'd0, 64'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
